br_history_checkpoint: RTL and testbench
========================================

Name: br_history_checkpoint

Overview:
- Stores the speculative global branch history for every predicted conditional branch in flight.
- Sits next to the gshare predictor. It captures the pre-prediction history that fetch hands out per branch, and on a mispredict it produces the recovery-history request that the predictor consumes.
- Replaces carrying full history words down the pipeline: branches carry a small checkpoint ID instead.

Parameters:
- ENTRY_NUM, 16, checkpoint slots (power of two, ≥4)
- HIST_W, 10, global history width in bits
- ALLOC_W, 2, allocation lanes per cycle (fetch width)
- RESOLVE_W, 2, resolve lanes per cycle (integer issue width)
- IDW, $clog2(ENTRY_NUM), checkpoint ID width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_valid  in  ALLOC_W  per-lane request to checkpoint one conditional branch
- alloc_hist  in  ALLOC_W*HIST_W  history before that branch's prediction
- alloc_ready  out  1  registered; 1 when free slots ≥ ALLOC_W
- alloc_id  out  ALLOC_W*IDW  combinational; ID given to each lane
- res_valid  in  RESOLVE_W  branch resolved
- res_id  in  RESOLVE_W*IDW  checkpoint ID of the resolved branch
- res_mispred  in  RESOLVE_W  direction mispredicted
- res_taken  in  RESOLVE_W  actual direction
- commit_cnt  in  $clog2(ALLOC_W+1)  oldest entries retired this cycle
- flush  in  1  full pipeline flush
- recover_valid  out  1  registered recovery pulse
- recover_hist  out  HIST_W  registered recovered history
- count  out  IDW+1  live entries

Behaviour:
- Circular buffer with head/tail pointers of IDW+1 bits; the extra bit is the wrap flag.
- empty: head==tail. count = tail−head (mod 2^(IDW+1)).
- Reset (rst_n=0, asynchronous):
  - head=tail=0
  - alloc_ready=1
  - recover_valid=0, recover_hist=0
  - storage contents are don't-care
- Allocation:
  - Accepted only when alloc_ready=1 and no mispredict recovery is taken this cycle (see Recovery).
  - Valid lanes are compacted. The k-th valid lane (k from 0, lane order) gets ID (tail+k) mod ENTRY_NUM, and its alloc_hist is written at the clock edge.
  - tail advances by popcount(alloc_valid).
  - alloc_id for an invalid lane is don't-care.
  - Allocating with alloc_ready=0 is ignored. Upstream must stall; the block does not flag an error.
- Age: age(id) = (id − head[IDW-1:0]) mod ENTRY_NUM.
  - A resolve is live when age < count. Non-live resolves are ignored (stale IDs after rollback or flush).
- Recovery:
  - Among live lanes with res_valid & res_mispred, select the one with the smallest age; ties cannot occur.
  - Next cycle: recover_valid=1 and recover_hist = {saved[sel][HIST_W-2:0], res_taken[sel]}, a one-cycle pulse.
  - At the same edge, tail ← head + age(sel) + 1; the offending entry stays live.
  - All allocations in that cycle are dropped.
- Commit: head advances by commit_cnt.
  - commit_cnt > count is illegal; the assertion fires in simulation.
  - Commit and recovery in the same cycle both apply: the rollback tail uses the pre-commit head plus age, and head advances independently.
- Flush: tail ← head + commit_cnt (empty after commit), recover_valid ← 0.
  - flush has priority over recovery and allocation in the same cycle.
- alloc_ready is registered from post-update count: ready = (ENTRY_NUM − count_next) ≥ ALLOC_W.
- Wrap-around: pointer arithmetic is modulo 2^(IDW+1). Full means count==ENTRY_NUM.
- Correct-prediction resolves change no state. The entry is freed only by commit.

Optional Feature:
- Macro: BR_HISTORY_CHECKPOINT_STATS_EN.
- With the macro defined, add outputs stat_recover (32 b) and stat_full_stall (32 b).
  - stat_recover counts recover_valid pulses.
  - stat_full_stall counts cycles with any alloc_valid while alloc_ready=0.
  - Both reset to 0 and saturate at all-ones.
- Without the macro: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset then alloc_valid=2'b11, hist 0x155/0x2AA -> alloc_id 0/1; next cycle count=2, alloc_ready=1.
- Alloc 4 entries (IDs 0-3, ID2 hist 0x0F3); resolve id2 mispred taken=1 -> next cycle recover_valid=1, recover_hist=0x1E7, count=3; res_id 3 afterwards is ignored.
- Same cycle: lane0 id5 mispred, lane1 id4 mispred with head=2 -> id4 selected; tail=5.
- Fill to 15 entries -> alloc_ready=0; two-lane alloc ignored and tail unchanged; commit_cnt=2 -> alloc_ready=1 next cycle.
- Wrap-around: head=14, alloc 4 -> IDs 14,15,0,1; resolve id1 mispred -> recover uses saved[1], count=4.
- flush with commit_cnt=1 and a concurrent mispredict -> count=0, recover_valid=0; assert rst_n mid-operation -> all outputs at reset values immediately.

Source files
------------

// File: rtl/br_history_checkpoint_if.sv
// Interface for br_history_checkpoint. It carries the allocation, resolve,
// commit/flush and recovery signals between the pipeline and the block.
// master = pipeline side (fetch/issue/retire), slave = the checkpoint block.
interface br_history_checkpoint_if #(
   parameter int ENTRY_NUM = 16,
   parameter int HIST_W    = 10,
   parameter int ALLOC_W   = 2,
   parameter int RESOLVE_W = 2
);
   localparam int IDW = $clog2(ENTRY_NUM);
   localparam int CW  = $clog2(ALLOC_W + 1);

   logic [ALLOC_W-1:0]        alloc_valid;
   logic [ALLOC_W*HIST_W-1:0] alloc_hist;
   logic                      alloc_ready;
   logic [ALLOC_W*IDW-1:0]    alloc_id;
   logic [RESOLVE_W-1:0]      res_valid;
   logic [RESOLVE_W*IDW-1:0]  res_id;
   logic [RESOLVE_W-1:0]      res_mispred;
   logic [RESOLVE_W-1:0]      res_taken;
   logic [CW-1:0]             commit_cnt;
   logic                      flush;
   logic                      recover_valid;
   logic [HIST_W-1:0]         recover_hist;
   logic [IDW:0]              count;

   modport master (
      output alloc_valid, alloc_hist, res_valid, res_id, res_mispred,
             res_taken, commit_cnt, flush,
      input  alloc_ready, alloc_id, recover_valid, recover_hist, count
   );

   modport slave (
      input  alloc_valid, alloc_hist, res_valid, res_id, res_mispred,
             res_taken, commit_cnt, flush,
      output alloc_ready, alloc_id, recover_valid, recover_hist, count
   );
endinterface

// File: rtl/br_history_checkpoint.sv
// br_history_checkpoint: circular buffer of pre-prediction global history
// words, one per in-flight conditional branch. Branches carry only the slot
// ID; on a mispredict the oldest offending branch's history (shifted by its
// real direction) is produced as a one-cycle recovery request and younger
// slots are rolled back.
// Optional statistics counters are enabled with BR_HISTORY_CHECKPOINT_STATS_EN.
module br_history_checkpoint #(
   parameter int ENTRY_NUM = 16,
   parameter int HIST_W    = 10,
   parameter int ALLOC_W   = 2,
   parameter int RESOLVE_W = 2,
   localparam int IDW      = $clog2(ENTRY_NUM),
   localparam int CW       = $clog2(ALLOC_W + 1),
   localparam int PW       = IDW + 1
) (
   input  logic clk,
   input  logic rst_n,
   br_history_checkpoint_if.slave bus
`ifdef BR_HISTORY_CHECKPOINT_STATS_EN
   ,
   output logic [31:0] stat_recover,
   output logic [31:0] stat_full_stall
`endif
);

   // Pointers carry one wrap bit above the slot index.
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic              r_alloc_ready;
   logic              r_recover_valid;
   logic [HIST_W-1:0] r_recover_hist;
   logic [HIST_W-1:0] r_hist_mem [ENTRY_NUM];

   logic [PW-1:0]     w_count;
   logic [PW-1:0]     w_head_next;
   logic [PW-1:0]     w_tail_next;
   logic [PW-1:0]     w_count_next;
   logic              w_ready_next;

   logic [CW-1:0]     w_alloc_rank [ALLOC_W];
   logic [CW-1:0]     w_alloc_pop;
   logic [IDW-1:0]    w_alloc_slot [ALLOC_W];
   logic              w_alloc_accept;

   logic [IDW-1:0]    w_res_id   [RESOLVE_W];
   logic [IDW-1:0]    w_res_age  [RESOLVE_W];
   logic [RESOLVE_W-1:0] w_res_cand;

   logic              w_sel_found;
   logic [IDW-1:0]    w_sel_age;
   logic [IDW-1:0]    w_sel_id;
   logic              w_sel_taken;
   logic              w_rec_take;

   assign w_count = r_tail - r_head;

   // Rank each valid allocation lane among the valid lanes before it.
   always_comb begin
      logic [CW-1:0] acc;
      acc = '0;
      for (int l = 0; l < ALLOC_W; l++) begin
         w_alloc_rank[l] = acc;
         acc = acc + CW'(bus.alloc_valid[l]);
      end
      w_alloc_pop = acc;
   end

   genvar gi;
   generate
      for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
         assign w_alloc_slot[gi] = r_tail[IDW-1:0] + IDW'(w_alloc_rank[gi]);
         assign bus.alloc_id[gi*IDW +: IDW] = w_alloc_slot[gi];
      end

      for (gi = 0; gi < RESOLVE_W; gi++) begin : g_res
         assign w_res_id[gi]   = bus.res_id[gi*IDW +: IDW];
         // Age relative to the oldest live entry; modulo arithmetic by width.
         assign w_res_age[gi]  = w_res_id[gi] - r_head[IDW-1:0];
         // Stale IDs (beyond the live window) are ignored.
         assign w_res_cand[gi] = bus.res_valid[gi] & bus.res_mispred[gi] &
                                 (PW'(w_res_age[gi]) < w_count);
      end
   endgenerate

   // Pick the oldest mispredicting live branch across resolve lanes.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_age   = '0;
      w_sel_id    = '0;
      w_sel_taken = 1'b0;
      for (int l = 0; l < RESOLVE_W; l++) begin
         if (w_res_cand[l] && (!w_sel_found || (w_res_age[l] < w_sel_age))) begin
            w_sel_found = 1'b1;
            w_sel_age   = w_res_age[l];
            w_sel_id    = w_res_id[l];
            w_sel_taken = bus.res_taken[l];
         end
      end
   end

   // Flush overrides recovery; recovery drops this cycle's allocations.
   assign w_rec_take     = w_sel_found & ~bus.flush;
   assign w_alloc_accept = r_alloc_ready & ~w_sel_found & ~bus.flush;
   assign w_head_next    = r_head + PW'(bus.commit_cnt);

   // Next tail: flush empties, rollback keeps the offender, else allocate.
   always_comb begin
      w_tail_next = r_tail;
      if (bus.flush) begin
         w_tail_next = w_head_next;
      end else if (w_rec_take) begin
         // Rollback uses the pre-commit head; commit moves head separately.
         w_tail_next = r_head + PW'(w_sel_age) + PW'(1);
      end else if (w_alloc_accept) begin
         w_tail_next = r_tail + PW'(w_alloc_pop);
      end
   end

   assign w_count_next = w_tail_next - w_head_next;
   assign w_ready_next = (w_count_next <= PW'(ENTRY_NUM - ALLOC_W));

   // Pointer, ready and recovery-output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_alloc_ready   <= 1'b1;
         r_recover_valid <= 1'b0;
         r_recover_hist  <= '0;
      end else begin
         r_head          <= w_head_next;
         r_tail          <= w_tail_next;
         r_alloc_ready   <= w_ready_next;
         r_recover_valid <= w_rec_take;
         if (w_rec_take) begin
            r_recover_hist <= {r_hist_mem[w_sel_id][HIST_W-2:0], w_sel_taken};
         end
      end
   end

   // History storage: one write per accepted allocation lane; no reset needed.
   always_ff @(posedge clk) begin
      for (int l = 0; l < ALLOC_W; l++) begin
         if (w_alloc_accept && bus.alloc_valid[l]) begin
            r_hist_mem[w_alloc_slot[l]] <= bus.alloc_hist[l*HIST_W +: HIST_W];
         end
      end
   end

   assign bus.alloc_ready   = r_alloc_ready;
   assign bus.recover_valid = r_recover_valid;
   assign bus.recover_hist  = r_recover_hist;
   assign bus.count         = w_count;

   // Retiring more entries than are live is an upstream bug.
   a_commit_le_count: assert property (
      @(posedge clk) disable iff (!rst_n) (PW'(bus.commit_cnt) <= w_count)
   );

`ifdef BR_HISTORY_CHECKPOINT_STATS_EN
   logic [31:0] r_stat_recover;
   logic [31:0] r_stat_full_stall;

   // Saturating counters: recovery pulses and stalled allocation cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_recover    <= '0;
         r_stat_full_stall <= '0;
      end else begin
         if (r_recover_valid && (r_stat_recover != '1)) begin
            r_stat_recover <= r_stat_recover + 32'd1;
         end
         if ((|bus.alloc_valid) && !r_alloc_ready && (r_stat_full_stall != '1)) begin
            r_stat_full_stall <= r_stat_full_stall + 32'd1;
         end
      end
   end

   assign stat_recover    = r_stat_recover;
   assign stat_full_stall = r_stat_full_stall;
`endif

endmodule

// File: tb/tb_br_history_checkpoint.sv
// Directed bench for br_history_checkpoint: allocation/compaction, recovery,
// oldest-selection, full stall, wrap-around, flush and asynchronous reset.
module tb_br_history_checkpoint;
   localparam int ENTRY_NUM = 16;
   localparam int HIST_W    = 10;
   localparam int ALLOC_W   = 2;
   localparam int RESOLVE_W = 2;
   localparam int IDW       = 4;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   br_history_checkpoint_if #(
      .ENTRY_NUM(ENTRY_NUM), .HIST_W(HIST_W),
      .ALLOC_W(ALLOC_W), .RESOLVE_W(RESOLVE_W)
   ) bus ();

`ifdef BR_HISTORY_CHECKPOINT_STATS_EN
   logic [31:0] stat_recover;
   logic [31:0] stat_full_stall;
`endif

   br_history_checkpoint #(
      .ENTRY_NUM(ENTRY_NUM), .HIST_W(HIST_W),
      .ALLOC_W(ALLOC_W), .RESOLVE_W(RESOLVE_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
`ifdef BR_HISTORY_CHECKPOINT_STATS_EN
      ,
      .stat_recover   (stat_recover),
      .stat_full_stall(stat_full_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.alloc_valid = '0;
      bus.alloc_hist  = '0;
      bus.res_valid   = '0;
      bus.res_id      = '0;
      bus.res_mispred = '0;
      bus.res_taken   = '0;
      bus.commit_cnt  = '0;
      bus.flush       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [1:0] v, input logic [9:0] h0, input logic [9:0] h1);
      bus.alloc_valid = v;
      bus.alloc_hist  = {h1, h0};
   endtask

   task automatic resolve(input int lane, input logic [3:0] id, input logic mis, input logic tk);
      bus.res_valid[lane]            = 1'b1;
      bus.res_id[lane*IDW +: IDW]    = id;
      bus.res_mispred[lane]          = mis;
      bus.res_taken[lane]            = tk;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b1;
      idle();

      // ---- Reset state and first two-lane allocation ----
      do_reset();
      check("rst_ready", 32'(bus.alloc_ready), 32'd1);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_rvalid", 32'(bus.recover_valid), 32'd0);
      check("rst_rhist", 32'(bus.recover_hist), 32'd0);
      alloc(2'b11, 10'h155, 10'h2AA);
      #1;
      check("t1_id0", 32'(bus.alloc_id[3:0]), 32'd0);
      check("t1_id1", 32'(bus.alloc_id[7:4]), 32'd1);
      tick();
      check("t1_count", 32'(bus.count), 32'd2);
      check("t1_ready", 32'(bus.alloc_ready), 32'd1);
      alloc(2'b10, 10'h000, 10'h123);     // lane1 only: compacted to tail
      #1;
      check("t1_compact_id1", 32'(bus.alloc_id[7:4]), 32'd2);
      tick();
      check("t1_count3", 32'(bus.count), 32'd3);

      // ---- Mispredict on id2, allocation dropped, stale id ignored ----
      do_reset();
      alloc(2'b11, 10'h100, 10'h101);
      tick();
      alloc(2'b11, 10'h0F3, 10'h0AA);
      #1;
      check("t2_id2", 32'(bus.alloc_id[3:0]), 32'd2);
      check("t2_id3", 32'(bus.alloc_id[7:4]), 32'd3);
      tick();
      check("t2_count4", 32'(bus.count), 32'd4);
      idle();
      alloc(2'b01, 10'h3FF, 10'h000);     // must be dropped by the recovery
      resolve(0, 4'd2, 1'b1, 1'b1);
      tick();
      check("t2_rvalid", 32'(bus.recover_valid), 32'd1);
      check("t2_rhist", 32'(bus.recover_hist), 32'h1E7);
      check("t2_count3", 32'(bus.count), 32'd3);
      idle();
      resolve(0, 4'd3, 1'b1, 1'b0);       // id3 no longer live
      tick();
      check("t2_stale_rvalid", 32'(bus.recover_valid), 32'd0);
      check("t2_stale_count", 32'(bus.count), 32'd3);
      check("t2_stale_rhist", 32'(bus.recover_hist), 32'h1E7);

      // ---- Oldest selection with head=2, plus concurrent commit ----
      do_reset();
      alloc(2'b11, 10'h000, 10'h001);
      tick();
      alloc(2'b11, 10'h002, 10'h003);
      tick();
      alloc(2'b11, 10'h204, 10'h305);
      bus.commit_cnt = 2'd2;
      tick();
      check("t3_count4", 32'(bus.count), 32'd4);
      idle();
      resolve(0, 4'd5, 1'b1, 1'b1);
      resolve(1, 4'd4, 1'b1, 1'b0);
      bus.commit_cnt = 2'd1;
      tick();
      check("t3_rvalid", 32'(bus.recover_valid), 32'd1);
      check("t3_rhist_id4", 32'(bus.recover_hist), 32'h008);
      check("t3_count2", 32'(bus.count), 32'd2);   // tail 5, head 3
      idle();

      // ---- Fill to 15, ignored allocation, commit restores ready ----
      do_reset();
      for (int c = 0; c < 7; c++) begin
         alloc(2'b11, 10'(c * 2), 10'(c * 2 + 1));
         tick();
      end
      check("t4_count14", 32'(bus.count), 32'd14);
      check("t4_ready14", 32'(bus.alloc_ready), 32'd1);
      alloc(2'b01, 10'h00E, 10'h000);
      tick();
      check("t4_count15", 32'(bus.count), 32'd15);
      check("t4_ready15", 32'(bus.alloc_ready), 32'd0);
      alloc(2'b11, 10'h111, 10'h222);
      #1;
      check("t4_full_id0", 32'(bus.alloc_id[3:0]), 32'd15);
      tick();
      check("t4_ignored_count", 32'(bus.count), 32'd15);
      bus.commit_cnt = 2'd2;
      tick();
      check("t4_commit_count", 32'(bus.count), 32'd13);
      check("t4_commit_ready", 32'(bus.alloc_ready), 32'd1);
      idle();

      // ---- Wrap-around from head=14 ----
      do_reset();
      alloc(2'b11, 10'h000, 10'h000);
      tick();
      for (int c = 0; c < 6; c++) begin
         alloc(2'b11, 10'h000, 10'h000);
         bus.commit_cnt = 2'd2;
         tick();
      end
      idle();
      bus.commit_cnt = 2'd2;
      tick();
      check("t5_empty", 32'(bus.count), 32'd0);
      idle();
      alloc(2'b11, 10'h0AB, 10'h0CD);
      #1;
      check("t5_id14", 32'(bus.alloc_id[3:0]), 32'd14);
      check("t5_id15", 32'(bus.alloc_id[7:4]), 32'd15);
      tick();
      alloc(2'b11, 10'h3C5, 10'h111);
      #1;
      check("t5_id0", 32'(bus.alloc_id[3:0]), 32'd0);
      check("t5_id1", 32'(bus.alloc_id[7:4]), 32'd1);
      tick();
      check("t5_count4", 32'(bus.count), 32'd4);
      idle();
      resolve(1, 4'd1, 1'b1, 1'b0);
      tick();
      check("t5_rvalid", 32'(bus.recover_valid), 32'd1);
      check("t5_rhist", 32'(bus.recover_hist), 32'h222);
      check("t5_count_after", 32'(bus.count), 32'd4);

      // ---- Flush beats concurrent mispredict, then async reset ----
      idle();
      bus.flush      = 1'b1;
      bus.commit_cnt = 2'd1;
      resolve(0, 4'd15, 1'b1, 1'b1);
      tick();
      check("t6_flush_count", 32'(bus.count), 32'd0);
      check("t6_flush_rvalid", 32'(bus.recover_valid), 32'd0);
      check("t6_flush_ready", 32'(bus.alloc_ready), 32'd1);
      idle();
      alloc(2'b11, 10'h001, 10'h002);
      tick();
      idle();
      check("t6_pre_rst_count", 32'(bus.count), 32'd2);
      check("t6_pre_rst_rhist", 32'(bus.recover_hist), 32'h222);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_count", 32'(bus.count), 32'd0);
      check("t6_async_ready", 32'(bus.alloc_ready), 32'd1);
      check("t6_async_rvalid", 32'(bus.recover_valid), 32'd0);
      check("t6_async_rhist", 32'(bus.recover_hist), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
